// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_t;

  function automatic logic md_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_md_sign_fix.sv
// Conditional two's-complement negate of a W-bit value.
module md_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one bit per cycle, with HI/LO result registers.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             abort,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_t        r_state;
  logic [CW-1:0]    r_count;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic             r_done;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  md_op_t             w_op;
  logic               w_signed;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_op     = md_op_t'(op);
  assign w_signed = md_is_signed(w_op);
  assign w_neg_a  = w_signed & src_a[WIDTH-1];
  assign w_neg_b  = w_signed & src_b[WIDTH-1];

  md_sign_fix #(.W(WIDTH)) u_abs_a (.i_val(src_a), .i_neg(w_neg_a), .o_val(w_abs_a));
  md_sign_fix #(.W(WIDTH)) u_abs_b (.i_val(src_b), .i_neg(w_neg_b), .o_val(w_abs_b));

  // Shift-add step: {acc,mplier} >> 1 after conditionally adding the multiplicand.
  assign w_sum    = {1'b0, r_acc} + {1'b0, r_mcand & {WIDTH{r_shift[0]}}};
  // Restoring step: top bit of the difference is the borrow.
  assign w_rem_sh = {r_acc, r_shift[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_mcand};

  md_sign_fix #(.W(2*WIDTH)) u_fix_prod (.i_val({r_acc, r_shift}), .i_neg(r_neg_q), .o_val(w_prod));
  md_sign_fix #(.W(WIDTH))   u_fix_quot (.i_val(r_shift), .i_neg(r_neg_q), .o_val(w_quot));
  md_sign_fix #(.W(WIDTH))   u_fix_rem  (.i_val(r_acc), .i_neg(r_neg_r), .o_val(w_rem));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= MD_IDLE;
      r_count  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_done   <= 1'b0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_shift  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      // MTHI/MTLO land only while idle, even alongside abort or start.
      if (r_state == MD_IDLE) begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end
      if (abort) begin
        r_state <= MD_IDLE;
      end else begin
        case (r_state)
          MD_IDLE: begin
            if (start) begin
              r_is_div <= md_is_div(w_op);
              r_neg_q  <= w_neg_a ^ w_neg_b;
              r_neg_r  <= w_neg_a;
              r_div0   <= (src_b == '0);
              r_mcand  <= md_is_div(w_op) ? w_abs_b : w_abs_a;
              r_shift  <= md_is_div(w_op) ? w_abs_a : w_abs_b;
              r_acc    <= '0;
              r_count  <= '0;
              r_state  <= MD_RUN;
            end
          end
          MD_RUN: begin
            if (r_is_div) begin
              r_acc   <= w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
              r_shift <= {r_shift[WIDTH-2:0], ~w_diff[WIDTH]};
            end else begin
              r_acc   <= w_sum[WIDTH:1];
              r_shift <= {w_sum[0], r_shift[WIDTH-1:1]};
            end
            r_count <= r_count + CW'(1);
            if (r_count == CW'(WIDTH - 1)) r_state <= MD_FIX;
          end
          MD_FIX: begin
            if (r_is_div) begin
              r_lo <= r_div0 ? '1 : w_quot;
              r_hi <= w_rem;
            end else begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end
            r_done  <= 1'b1;
            r_state <= MD_IDLE;
          end
          default: r_state <= MD_IDLE;
        endcase
      end
    end
  end

  assign busy = (r_state != MD_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: cycle-level behavioural model plus literal spot checks.
module tb_muldiv_unit;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = W + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         abort = 1'b0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks   = 0;
  int failures = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .abort(abort), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Architectural result of one operation, straight from the arithmetic definition.
  function automatic logic [63:0] calc(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b);
    longint    sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f_op)
      2'b00: begin p = 64'(sa * sb); return p; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; return p; end
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  int          m_cnt  = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [63:0] m_res  = '0;
  logic        m_idle;

  // Model: busy is a countdown of remaining cycles; result appears when it expires.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt = 0; m_done = 1'b0; m_hi = '0; m_lo = '0;
    end else begin
      m_idle = (m_cnt == 0);
      m_done = 1'b0;
      if (m_idle) begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
      end
      if (abort) m_cnt = 0;
      else if (m_idle) begin
        if (start) begin
          m_res = calc(op, src_a, src_b);
          m_cnt = LAT;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          {m_hi, m_lo} = m_res;
          m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_cnt != 0));
    chk("done", 64'(done), 64'(m_done));
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
  end

  // Launch one op and wait for done; reports edges to done and busy-cycle count.
  task automatic run_op(input logic [1:0] t_op, input logic [31:0] a, input logic [31:0] b,
                        input bit noise, output int n, output int nbusy);
    @(negedge clk);
    op = t_op; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    nbusy = busy ? 1 : 0;
    while (1) begin
      @(negedge clk);
      n++;
      hi_we = 1'b0; lo_we = 1'b0;
      if (busy) nbusy++;
      if (done) break;
      if (n > 100) begin
        chk("timeout", 64'(n), 64'(LAT));
        break;
      end
      if (noise) begin
        hi_we = ($urandom_range(0, 5) == 0);
        lo_we = ($urandom_range(0, 5) == 0);
        wdata = $urandom;
      end
    end
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int n, nb, cnt;
  logic [31:0] ra, rb;

  initial begin
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hi", 64'(hi), 64'h0);
    chk("reset_lo", 64'(lo), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_done", 64'(done), 64'h0);
    reset = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, n, nb);
    chk("multu_latency", 64'(n), 64'd33);
    chk("multu_busy_cycles", 64'(nb), 64'd33);
    chk("multu_max", {32'(hi), 32'(lo)}, 64'hFFFF_FFFE_0000_0001);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, n, nb);
    chk("mult_neg", {32'(hi), 32'(lo)}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, n, nb);
    chk("div_neg", {32'(hi), 32'(lo)}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b11, 32'd100, 32'd0, 1'b0, n, nb);
    chk("divu_zero", {32'(hi), 32'(lo)}, 64'h0000_0064_FFFF_FFFF);
    chk("divu_zero_latency", 64'(n), 64'd33);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, n, nb);
    chk("div_ovf", {32'(hi), 32'(lo)}, 64'h0000_0000_8000_0000);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, n, nb);
    chk("mult_min_sq", {32'(hi), 32'(lo)}, 64'h4000_0000_0000_0000);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0, n, nb);
    chk("div_neg_zero", {32'(hi), 32'(lo)}, 64'hFFFF_FFF9_FFFF_FFFF);

    // Abort mid-run: no done, HI/LO keep the INT_MIN-squared... then the div0 result.
    @(negedge clk);
    op = 2'b11; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'h0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("abort_no_done", 64'(cnt), 64'h0);
    chk("abort_keep", {32'(hi), 32'(lo)}, 64'hFFFF_FFF9_FFFF_FFFF);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, n, nb);
    chk("divu_after_abort", {32'(hi), 32'(lo)}, 64'h0000_0002_0000_000E);

    // Write while busy is dropped.
    @(negedge clk);
    op = 2'b01; src_a = 32'd6; src_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    cnt = 0;
    while (!done && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("busy_write_dropped", {32'(hi), 32'(lo)}, 64'h0000_0000_0000_002A);

    lo_we = 1'b1; wdata = 32'hBEEF;
    @(negedge clk);
    lo_we = 1'b0;
    chk("idle_lo_write", 64'(lo), 64'hBEEF);

    // Abort with start and write in IDLE: start dropped, write lands.
    start = 1'b1; abort = 1'b1; hi_we = 1'b1; wdata = 32'h5555;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; hi_we = 1'b0;
    chk("abort_start_busy", 64'(busy), 64'h0);
    chk("abort_write_hi", 64'(hi), 64'h5555);

    // Write with start lands, then the result overwrites it.
    op = 2'b01; src_a = 32'd3; src_b = 32'd5; start = 1'b1; lo_we = 1'b1; wdata = 32'h7777;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    chk("start_write_lands", 64'(lo), 64'h7777);
    cnt = 0;
    while (!done && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("start_write_overwritten", 64'(lo), 64'd15);

    // Reset mid-run.
    @(negedge clk);
    op = 2'b01; src_a = 32'd123; src_b = 32'd456; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_hi", 64'(hi), 64'h0);
    chk("midrst_lo", 64'(lo), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    run_op(2'b01, 32'd6, 32'd7, 1'b0, n, nb);
    chk("multu_after_reset", {32'(hi), 32'(lo)}, 64'h0000_0000_0000_002A);

    // Randomized ops with random MTHI/MTLO noise while busy.
    for (int i = 0; i < 60; i++) begin
      ra = pick_val();
      rb = pick_val();
      run_op(2'($urandom_range(0, 3)), ra, rb, 1'b1, n, nb);
      chk("rand_latency", 64'(n), 64'd33);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
